// File: rtl/bram_burst_reader.sv
// Burst read initiator on a single-port BRAM; returns words as a valid/ready stream with a last flag.
// Define BRAM_RD_PERF_EN to add the perf_busy_cycles / perf_stall_cycles counters.
module bram_burst_reader #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int LEN_WIDTH  = 16,
  parameter int RD_LATENCY = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [LEN_WIDTH-1:0]  cmd_len,
  output logic [ADDR_WIDTH-1:0] bram_addr,
  output logic [DATA_WIDTH-1:0] bram_wdata,
  output logic                  bram_we,
  output logic                  bram_en,
  input  logic [DATA_WIDTH-1:0] bram_rdata,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_last,
  output logic                  busy,
  output logic                  done
`ifdef BRAM_RD_PERF_EN
  ,
  output logic [31:0]           perf_busy_cycles,
  output logic [31:0]           perf_stall_cycles
`endif
);

  localparam int BYTES = DATA_WIDTH / 8;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 2;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;
  state_t state_reg, state_next;

  logic [ADDR_WIDTH-1:0] cur_addr_reg;
  logic [LEN_WIDTH-1:0]  remaining_reg;
  logic [RD_LATENCY-1:0] pipe_valid_reg, pipe_last_reg;
  logic [DATA_WIDTH-1:0] fifo_data_mem [FIFO_DEPTH];
  logic                  fifo_last_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_reg, rd_ptr_reg;
  logic [CNT_W-1:0]      fifo_count_reg, inflight;
  logic                  done_reg;
  logic                  accept, issue, credit, push, pop, last_issue, last_pop;

  // Reads still travelling through the BRAM latency pipe.
  always_comb begin
    inflight = '0;
    for (int i = 0; i < RD_LATENCY; i++)
      inflight = inflight + CNT_W'(pipe_valid_reg[i]);
  end

  // Every outstanding read has a reserved FIFO slot, so pushes can never overflow.
  assign credit     = (inflight + fifo_count_reg) < CNT_W'(FIFO_DEPTH);
  assign accept     = cmd_valid && cmd_ready;
  assign issue      = bram_en;
  assign last_issue = issue && (remaining_reg == LEN_WIDTH'(1));
  assign push       = pipe_valid_reg[RD_LATENCY-1];
  assign pop        = m_valid && m_ready;
  assign last_pop   = pop && m_last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (accept && (cmd_len != '0)) state_next = ISSUE;
      ISSUE:   if (last_issue) state_next = DRAIN;
      DRAIN:   if (last_pop) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    cmd_ready = 1'b0;
    busy      = 1'b0;
    bram_en   = 1'b0;
    case (state_reg)
      IDLE:    cmd_ready = 1'b1;
      ISSUE: begin
        busy    = 1'b1;
        bram_en = credit;
      end
      DRAIN:   busy = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_addr_reg   <= '0;
      remaining_reg  <= '0;
      pipe_valid_reg <= '0;
      pipe_last_reg  <= '0;
      wr_ptr_reg     <= '0;
      rd_ptr_reg     <= '0;
      fifo_count_reg <= '0;
      done_reg       <= 1'b0;
    end else begin
      if (accept) begin
        cur_addr_reg  <= cmd_addr;
        remaining_reg <= cmd_len;
      end else if (issue) begin
        cur_addr_reg  <= cur_addr_reg + ADDR_WIDTH'(BYTES);
        remaining_reg <= remaining_reg - LEN_WIDTH'(1);
      end
      for (int i = RD_LATENCY - 1; i > 0; i--) begin
        pipe_valid_reg[i] <= pipe_valid_reg[i-1];
        pipe_last_reg[i]  <= pipe_last_reg[i-1];
      end
      pipe_valid_reg[0] <= issue;
      pipe_last_reg[0]  <= last_issue;
      if (push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      fifo_count_reg <= fifo_count_reg + CNT_W'(push) - CNT_W'(pop);
      done_reg       <= (accept && (cmd_len == '0)) || last_pop;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_data_mem[wr_ptr_reg] <= bram_rdata;
      fifo_last_mem[wr_ptr_reg] <= pipe_last_reg[RD_LATENCY-1];
    end
  end

  assign bram_addr  = cur_addr_reg;
  assign bram_wdata = '0;
  assign bram_we    = 1'b0;
  assign m_valid    = (fifo_count_reg != '0);
  assign m_data     = m_valid ? fifo_data_mem[rd_ptr_reg] : '0;
  assign m_last     = m_valid && fifo_last_mem[rd_ptr_reg];
  assign done       = done_reg;

`ifdef BRAM_RD_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_busy_cycles  <= '0;
      perf_stall_cycles <= '0;
    end else if (accept) begin
      perf_busy_cycles  <= '0;
      perf_stall_cycles <= '0;
    end else begin
      if (busy && (perf_busy_cycles != '1))
        perf_busy_cycles <= perf_busy_cycles + 32'd1;
      if ((state_reg == ISSUE) && !credit && (perf_stall_cycles != '1))
        perf_stall_cycles <= perf_stall_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_bram_burst_reader.sv
// Scoreboard bench for bram_burst_reader: one instance per read latency (1 and 2), each with its own BRAM model.
module tb_bram_burst_reader;
  localparam int FD = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, cmd_valid, m_ready;
  logic [31:0] cmd_addr;
  logic [15:0] cmd_len;
  int          sel;
  int          cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        cmd_ready1, we1, en1, m_valid1, m_last1, busy1, done1;
  logic        cmd_ready2, we2, en2, m_valid2, m_last2, busy2, done2;
  logic [31:0] addr1, wdata1, rdata1, m_data1, addr2, wdata2, rdata2, m_data2, stage2;
  logic        cv1, cv2;
  assign cv1 = cmd_valid && (sel == 0);
  assign cv2 = cmd_valid && (sel == 1);
`ifdef BRAM_RD_PERF_EN
  logic [31:0] pb1, ps1, pb2, ps2;
`endif

  bram_burst_reader #(.RD_LATENCY(1), .FIFO_DEPTH(FD)) dut1 (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cv1), .cmd_ready(cmd_ready1),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len), .bram_addr(addr1), .bram_wdata(wdata1),
    .bram_we(we1), .bram_en(en1), .bram_rdata(rdata1), .m_valid(m_valid1),
    .m_ready(m_ready), .m_data(m_data1), .m_last(m_last1), .busy(busy1), .done(done1)
`ifdef BRAM_RD_PERF_EN
    , .perf_busy_cycles(pb1), .perf_stall_cycles(ps1)
`endif
  );

  bram_burst_reader #(.RD_LATENCY(2), .FIFO_DEPTH(FD)) dut2 (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cv2), .cmd_ready(cmd_ready2),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len), .bram_addr(addr2), .bram_wdata(wdata2),
    .bram_we(we2), .bram_en(en2), .bram_rdata(rdata2), .m_valid(m_valid2),
    .m_ready(m_ready), .m_data(m_data2), .m_last(m_last2), .busy(busy2), .done(done2)
`ifdef BRAM_RD_PERF_EN
    , .perf_busy_cycles(pb2), .perf_stall_cycles(ps2)
`endif
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hC3C3_0F0F;
  endfunction

  // BRAM models: data valid exactly RD_LATENCY cycles after the enable, junk otherwise.
  always @(posedge clk) rdata1 <= en1 ? mem_word(addr1) : 32'hDEAD_BEEF;
  always @(posedge clk) begin
    stage2 <= en2 ? mem_word(addr2) : 32'hDEAD_BEEF;
    rdata2 <= stage2;
  end

  logic        cmd_ready, bram_en, m_valid, m_last, busy, done;
  logic [31:0] bram_addr, m_data;
  assign cmd_ready = (sel == 1) ? cmd_ready2 : cmd_ready1;
  assign bram_en   = (sel == 1) ? en2        : en1;
  assign bram_addr = (sel == 1) ? addr2      : addr1;
  assign m_valid   = (sel == 1) ? m_valid2   : m_valid1;
  assign m_data    = (sel == 1) ? m_data2    : m_data1;
  assign m_last    = (sel == 1) ? m_last2    : m_last1;
  assign busy      = (sel == 1) ? busy2      : busy1;
  assign done      = (sel == 1) ? done2      : done1;

  logic [31:0] exp_addr_q[$];
  logic [31:0] exp_data_q[$];
  bit          exp_last_q[$];

  int total = 0, bad = 0;
  int en_cnt, beat_cnt, done_cnt, valid_cnt, out_cnt, max_out;
  int first_en_cyc, last_en_cyc, first_valid_cyc, last_hs_cyc, done_cyc;
  bit          prev_stall;
  logic [31:0] prev_data, ea, ed;
  logic        prev_last;
  bit          el;

  // Scoreboard monitor: every read address and every handshaken beat is popped and compared.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bram_en) begin
        en_cnt++;
        out_cnt++;
        if (first_en_cyc < 0) first_en_cyc = cyc;
        last_en_cyc = cyc;
        total++;
        if (exp_addr_q.size() == 0) begin
          bad++;
          $display("FAIL bram_addr unexpected read got=%h", bram_addr);
        end else begin
          ea = exp_addr_q.pop_front();
          if (bram_addr !== ea) begin
            bad++;
            $display("FAIL bram_addr got=%h exp=%h", bram_addr, ea);
          end
        end
      end
      if (m_valid) begin
        valid_cnt++;
        if (first_valid_cyc < 0) first_valid_cyc = cyc;
      end
      if (prev_stall) begin
        total++;
        if (!m_valid || m_data !== prev_data || m_last !== prev_last) begin
          bad++;
          $display("FAIL hold_stable got v=%b d=%h l=%b exp v=1 d=%h l=%b", m_valid, m_data, m_last, prev_data, prev_last);
        end
      end
      if (m_valid && m_ready) begin
        beat_cnt++;
        out_cnt--;
        last_hs_cyc = cyc;
        total++;
        if (exp_data_q.size() == 0) begin
          bad++;
          $display("FAIL m_data unexpected beat got=%h", m_data);
        end else begin
          ed = exp_data_q.pop_front();
          el = exp_last_q.pop_front();
          if (m_data !== ed || m_last !== el) begin
            bad++;
            $display("FAIL m_data beat=%0d got=%h/%b exp=%h/%b", beat_cnt, m_data, m_last, ed, el);
          end
        end
      end
      prev_stall = m_valid && !m_ready;
      prev_data  = m_data;
      prev_last  = m_last;
      if (out_cnt > max_out) max_out = out_cnt;
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end else begin
      prev_stall = 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_stats();
    en_cnt = 0; beat_cnt = 0; done_cnt = 0; valid_cnt = 0; out_cnt = 0; max_out = 0;
    first_en_cyc = -1; last_en_cyc = -1; first_valid_cyc = -1; last_hs_cyc = -1; done_cyc = -1;
    prev_stall = 1'b0;
  endtask

  // Queues the expected words, then holds the command until the accepting edge (acc_edge = its cycle index).
  task automatic send_cmd(input logic [31:0] a, input logic [15:0] n, output int acc_edge);
    logic [31:0] wa;
    for (int i = 0; i < int'(n); i++) begin
      wa = a + 32'(i) * 32'd4;
      exp_addr_q.push_back(wa);
      exp_data_q.push_back(mem_word(wa));
      exp_last_q.push_back(i == int'(n) - 1);
    end
    cmd_valid = 1'b1; cmd_addr = a; cmd_len = n; acc_edge = -1;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (cmd_ready) begin
        acc_edge = cyc + 1;
        break;
      end
    end
    total++;
    if (acc_edge < 0) begin
      bad++;
      $display("FAIL cmd_accept timeout got=none exp=accept");
    end
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    bit seen = 1'b0;
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    #1;
    total++;
    if (!seen) begin
      bad++;
      $display("FAIL done_timeout got=0 exp=1");
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_addr = '0; cmd_len = '0; m_ready = 1'b1; sel = 0;
    clear_stats();
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    total++;
    if ({cmd_ready1, m_valid1, en1, busy1, done1, m_last1, we1} !== 7'b1000000) begin
      bad++;
      $display("FAIL reset_ctrl_l1 got=%b exp=1000000", {cmd_ready1, m_valid1, en1, busy1, done1, m_last1, we1});
    end
    total++;
    if ({cmd_ready2, m_valid2, en2, busy2, done2, m_last2, we2} !== 7'b1000000) begin
      bad++;
      $display("FAIL reset_ctrl_l2 got=%b exp=1000000", {cmd_ready2, m_valid2, en2, busy2, done2, m_last2, we2});
    end
    total++;
    if ({addr1, m_data1, wdata1} !== 96'h0) begin
      bad++;
      $display("FAIL reset_data got=%h exp=0", {addr1, m_data1, wdata1});
    end
  endtask

  task automatic test_basic(input int lat);
    int acc;
    sel = lat - 1; m_ready = 1'b1;
    clear_stats();
    send_cmd(32'h100, 16'd4, acc);
    wait_done(100);
    repeat (3) tick();
    total++;
    if (en_cnt != 4 || last_en_cyc - first_en_cyc != 3 || first_en_cyc != acc) begin
      bad++;
      $display("FAIL basic_issue L=%0d got cnt=%0d span=%0d start=%0d exp cnt=4 span=3 start=%0d",
               lat, en_cnt, last_en_cyc - first_en_cyc, first_en_cyc, acc);
    end
    total++;
    if (first_valid_cyc != acc + lat + 1) begin
      bad++;
      $display("FAIL basic_latency L=%0d got=%0d exp=%0d", lat, first_valid_cyc, acc + lat + 1);
    end
    total++;
    if (beat_cnt != 4 || done_cnt != 1 || done_cyc != last_hs_cyc + 1) begin
      bad++;
      $display("FAIL basic_done L=%0d got beats=%0d dones=%0d at=%0d exp beats=4 dones=1 at=%0d",
               lat, beat_cnt, done_cnt, done_cyc, last_hs_cyc + 1);
    end
  endtask

  task automatic test_backpressure(input int lat);
    int acc;
    bit hit = 1'b0;
    sel = lat - 1; m_ready = 1'b1;
    clear_stats();
    send_cmd(32'h2000, 16'd16, acc);
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      #1;
      if (beat_cnt >= 2) begin
        hit = 1'b1;
        break;
      end
    end
    total++;
    if (!hit) begin
      bad++;
      $display("FAIL bp_beat2 timeout got=%0d exp=2", beat_cnt);
    end
    tick();
    m_ready = 1'b0;
    repeat (10) tick();
    m_ready = 1'b1;
    wait_done(200);
    repeat (2) tick();
    total++;
    if (max_out != FD) begin
      bad++;
      $display("FAIL bp_outstanding L=%0d got=%0d exp=%0d", lat, max_out, FD);
    end
    total++;
    if (en_cnt != 16 || beat_cnt != 16 || done_cnt != 1 || exp_data_q.size() != 0) begin
      bad++;
      $display("FAIL bp_delivery L=%0d got en=%0d beats=%0d dones=%0d left=%0d exp 16/16/1/0",
               lat, en_cnt, beat_cnt, done_cnt, exp_data_q.size());
    end
  endtask

  task automatic test_zero_len();
    int acc;
    sel = 0; m_ready = 1'b1;
    clear_stats();
    send_cmd(32'h300, 16'd0, acc);
    repeat (4) tick();
    total++;
    if (en_cnt != 0 || valid_cnt != 0 || done_cnt != 1 || done_cyc != acc) begin
      bad++;
      $display("FAIL zero_len got en=%0d valid=%0d dones=%0d at=%0d exp 0/0/1 at=%0d",
               en_cnt, valid_cnt, done_cnt, done_cyc, acc);
    end
  endtask

  task automatic test_wrap();
    int acc;
    sel = 0; m_ready = 1'b1;
    clear_stats();
    send_cmd(32'hFFFF_FFFC, 16'd2, acc);
    wait_done(100);
    repeat (2) tick();
    total++;
    if (en_cnt != 2 || beat_cnt != 2 || exp_addr_q.size() != 0) begin
      bad++;
      $display("FAIL wrap got en=%0d beats=%0d left=%0d exp 2/2/0", en_cnt, beat_cnt, exp_addr_q.size());
    end
  endtask

  task automatic test_reset_mid();
    int acc;
    sel = 0; m_ready = 1'b1;
    clear_stats();
    send_cmd(32'h400, 16'd8, acc);
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      #1;
      if (beat_cnt >= 2) break;
    end
    tick();
    rst_n = 1'b0;
    #1;
    total++;
    if ({m_valid, bram_en, busy, done} !== 4'b0000) begin
      bad++;
      $display("FAIL reset_mid got=%b exp=0000", {m_valid, bram_en, busy, done});
    end
    exp_addr_q.delete(); exp_data_q.delete(); exp_last_q.delete();
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    total++;
    if (cmd_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_release_ready got=%b exp=1", cmd_ready);
    end
    clear_stats();
    send_cmd(32'h500, 16'd2, acc);
    wait_done(100);
    repeat (2) tick();
    total++;
    if (en_cnt != 2 || beat_cnt != 2 || exp_data_q.size() != 0) begin
      bad++;
      $display("FAIL reset_rerun got en=%0d beats=%0d left=%0d exp 2/2/0", en_cnt, beat_cnt, exp_data_q.size());
    end
  endtask

  task automatic test_back_to_back();
    int  acc;
    bit  seen = 1'b0;
    logic [31:0] wa;
    sel = 0; m_ready = 1'b1;
    clear_stats();
    send_cmd(32'h600, 16'd4, acc);
    for (int i = 0; i < 3; i++) begin
      wa = 32'h700 + 32'(i) * 32'd4;
      exp_addr_q.push_back(wa);
      exp_data_q.push_back(mem_word(wa));
      exp_last_q.push_back(i == 2);
    end
    cmd_valid = 1'b1; cmd_addr = 32'h700; cmd_len = 16'd3;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (cmd_ready) begin
        seen = 1'b1;
        break;
      end
    end
    total++;
    if (!seen || done !== 1'b1) begin
      bad++;
      $display("FAIL b2b_accept_in_done got ready=%b done=%b exp ready=1 done=1", seen, done);
    end
    tick();
    cmd_valid = 1'b0;
    wait_done(100);
    repeat (2) tick();
    total++;
    if (en_cnt != 7 || beat_cnt != 7 || done_cnt != 2 || exp_data_q.size() != 0) begin
      bad++;
      $display("FAIL b2b_delivery got en=%0d beats=%0d dones=%0d left=%0d exp 7/7/2/0",
               en_cnt, beat_cnt, done_cnt, exp_data_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_basic(1);
    test_backpressure(1);
    test_zero_len();
    test_wrap();
    test_reset_mid();
    test_back_to_back();
    test_basic(2);
    test_backpressure(2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
